// File: rtl/cdc_in_arbiter.sv
// cdc_in_arbiter: round-robin arbiter sharing the usb_cdc IN byte channel
// among N_REQ application streams, one bounded burst (one bulk packet) per grant.
//
// Ports:
//   clk_i, rst_i      app clock, asynchronous active-high reset
//   req_data_i        byte of requester k on bits [8k+7:8k]
//   req_valid_i       requester k has a byte
//   req_ready_o       byte of requester k accepted this cycle
//   in_data_o         byte towards usb_cdc in_data_i
//   in_valid_o        valid towards usb_cdc in_valid_i
//   in_ready_i        ready from usb_cdc in_ready_o
//   grant_o           one-hot current owner, zero when idle
//   busy_o            high while a grant is active
module cdc_in_arbiter #(
    parameter int N_REQ = 2,
    parameter int BURST = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         in_data_o,
    output logic               in_valid_o,
    input  logic               in_ready_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IW-1:0]    win_idx;
    logic             win_found;
    logic             xfer;
    int               idx;

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        win_idx   = last_q;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!win_found && req_valid_i[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    // While granted, last_q holds the owner index, so it drives the mux.
    always_comb begin
        grant_o     = '0;
        busy_o      = 1'b0;
        in_data_o   = 8'h00;
        in_valid_o  = 1'b0;
        req_ready_o = '0;
        if (state_q == S_GRANT) begin
            grant_o     = grant_q;
            busy_o      = 1'b1;
            in_data_o   = req_data_i[8*last_q +: 8];
            in_valid_o  = req_valid_i[last_q];
            req_ready_o = grant_q & {N_REQ{in_ready_i}};
        end
    end

    assign xfer = in_valid_o && in_ready_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    grant_d = N_REQ'(1) << win_idx;
                    last_d  = win_idx;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (!in_valid_o) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Testbench for cdc_in_arbiter: randomized requesters and sink checked
// against a transaction-level round-robin model and byte scoreboard.
module tb_cdc_in_arbiter;

    localparam int N = 4;
    localparam int B = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    cdc_in_arbiter #(.N_REQ(N), .BURST(B)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_data_i  (req_data),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .in_data_o   (in_data),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] srcq[N][$];
    logic [7:0] expq[N][$];
    logic [7:0] rxq[N][$];
    int         vprob[N];
    int         rprob;
    bit         rpat[$];
    int         bowner[$];
    int         blen[$];

    // model: owner (-1 idle), bytes sent in current grant, last winner
    int m_owner;
    int m_cnt;
    int m_last;

    logic [N-1:0] hs;
    logic [N-1:0] pg;
    logic [N-1:0] s_g, s_rv, s_rr;
    logic [7:0]   s_d;
    logic         s_iv, s_ir;
    logic [17:0]  exp_v, act_v;

    function automatic int oh2i(logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    function automatic bit rx_ok();
        for (int k = 0; k < N; k++) begin
            if (rxq[k].size() != expq[k].size()) return 1'b0;
            for (int j = 0; j < rxq[k].size(); j++)
                if (rxq[k][j] !== expq[k][j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push(int k, logic [7:0] b);
        srcq[k].push_back(b);
        expq[k].push_back(b);
    endtask

    task automatic drive();
        bit v;
        for (int k = 0; k < N; k++) begin
            if (req_valid[k] && !hs[k]) v = 1'b1;
            else if (srcq[k].size() > 0 &&
                     int'($urandom_range(99)) < vprob[k]) v = 1'b1;
            else v = 1'b0;
            req_valid[k] = v;
            req_data[8*k +: 8] = (srcq[k].size() > 0) ?
                                 srcq[k][0] : 8'($urandom);
        end
        if (m_owner >= 0 && rpat.size() > 0)
            in_ready = rpat.pop_front();
        else
            in_ready = (int'($urandom_range(99)) < rprob);
    endtask

    task automatic model_edge();
        if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                int c = (m_last + i) % N;
                if (req_valid[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_owner = -1;
        end else if (in_ready) begin
            m_cnt++;
            if (m_cnt == B) m_owner = -1;
        end
    endtask

    // One clock: commit last sample, step model, drive, sample at negedge.
    task automatic tick();
        logic [N-1:0] eg, er;
        logic         ev;
        logic [7:0]   ed;
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = N - 1;
            hs      = '0;
            pg      = '0;
        end else begin
            hs = s_rv & s_rr;
            for (int k = 0; k < N; k++)
                if (hs[k]) void'(srcq[k].pop_front());
            if (s_g != 0 && pg == 0) begin
                bowner.push_back(oh2i(s_g));
                blen.push_back(0);
            end
            if (s_g != 0 && s_iv && s_ir) begin
                rxq[oh2i(s_g)].push_back(s_d);
                blen[blen.size()-1] = blen[blen.size()-1] + 1;
            end
            pg = s_g;
            model_edge();
        end
        #1;
        drive();
        @(negedge clk);
        eg = '0; ev = 1'b0; ed = 8'h00; er = '0;
        if (m_owner >= 0 && !rst) begin
            eg[m_owner] = 1'b1;
            ev = req_valid[m_owner];
            ed = req_data[8*m_owner +: 8];
            er[m_owner] = in_ready;
        end
        exp_v = {eg, (m_owner >= 0 && !rst), ev, ed, er};
        act_v = {grant, busy, in_valid, in_data, req_ready};
        s_g  = grant;
        s_rv = req_valid;
        s_rr = req_ready;
        s_d  = in_data;
        s_iv = in_valid;
        s_ir = in_ready;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        in_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            srcq[k].delete();
            expq[k].delete();
            rxq[k].delete();
            vprob[k] = 0;
        end
        rprob = 100;
        rpat.delete();
        bowner.delete();
        blen.delete();
        @(negedge clk);
        m_owner = -1; m_cnt = 0; m_last = N - 1;
        hs = '0; pg = '0;
        s_g = '0; s_rv = '0; s_rr = '0;
        s_d = 8'h00; s_iv = 1'b0; s_ir = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        in_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        if ({grant, busy, in_valid, in_data, req_ready} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outs got=%h want=0",
                     {grant, busy, in_valid, in_data, req_ready});
        end
        checks++;
        req_valid = 4'b1111;
        in_ready = 1'b1;
        req_data = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        if ({grant, busy, in_valid, in_data, req_ready} !== 18'h0) begin
            errors++;
            $display("FAIL reset_held got=%h want=0",
                     {grant, busy, in_valid, in_data, req_ready});
        end
        checks++;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL reset_idle got=%h want=%h", act_v, exp_v);
            end
            checks++;
        end
    endtask

    task automatic test_single();
        int fv = -1, fg = -1, nhs = 0;
        do_reset();
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        vprob[0] = 100;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL single_cyc got=%h want=%h", act_v, exp_v);
            end
            checks++;
            if (req_valid[0] && fv < 0) fv = i;
            if (grant == 4'b0001 && fg < 0) fg = i;
            if (req_valid[0] && req_ready[0]) nhs++;
        end
        if (fg != fv + 1) begin
            errors++;
            $display("FAIL single_lat got=%0d want=%0d", fg, fv + 1);
        end
        checks++;
        if (nhs != 3) begin
            errors++;
            $display("FAIL single_hs got=%0d want=3", nhs);
        end
        checks++;
        if (!rx_ok() || bowner.size() != 1 || blen[0] != 3) begin
            errors++;
            $display("FAIL single_data got=%0d bursts want=1 of 3",
                     bowner.size());
        end
        checks++;
    endtask

    task automatic test_alternate();
        do_reset();
        for (int j = 0; j < 24; j++) begin
            push(0, 8'(j));
            push(1, 8'(8'h80 + j));
        end
        vprob[0] = 100;
        vprob[1] = 100;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL alt_cyc got=%h want=%h", act_v, exp_v);
            end
            checks++;
        end
        if (bowner.size() != 6) begin
            errors++;
            $display("FAIL alt_nburst got=%0d want=6", bowner.size());
        end
        checks++;
        for (int j = 0; j < bowner.size(); j++) begin
            if (bowner[j] != j % 2 || blen[j] != B) begin
                errors++;
                $display("FAIL alt_burst%0d got=%0d/%0d want=%0d/%0d",
                         j, bowner[j], blen[j], j % 2, B);
            end
            checks++;
        end
        if (!rx_ok()) begin
            errors++;
            $display("FAIL alt_data got=bad want=in-order");
        end
        checks++;
    endtask

    task automatic test_long();
        int fb = -1, lb = -1;
        int want[3] = '{8, 8, 4};
        do_reset();
        for (int j = 0; j < 20; j++) push(1, 8'(8'h40 + j));
        vprob[1] = 100;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL long_cyc got=%h want=%h", act_v, exp_v);
            end
            checks++;
            if (busy) begin
                if (fb < 0) fb = i;
                lb = i;
            end
        end
        if (bowner.size() != 3) begin
            errors++;
            $display("FAIL long_nburst got=%0d want=3", bowner.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (bowner[j] != 1 || blen[j] != want[j]) begin
                    errors++;
                    $display("FAIL long_burst%0d got=%0d/%0d want=1/%0d",
                             j, bowner[j], blen[j], want[j]);
                end
                checks++;
            end
        end
        checks++;
        if (lb - fb + 1 != 23) begin
            errors++;
            $display("FAIL long_span got=%0d want=23", lb - fb + 1);
        end
        checks++;
        if (!rx_ok()) begin
            errors++;
            $display("FAIL long_data got=bad want=in-order");
        end
        checks++;
    endtask

    task automatic test_backpressure();
        int nb = 0;
        bit stall = 1'b0;
        logic [7:0] pd = 8'h00;
        do_reset();
        for (int j = 0; j < 8; j++) push(0, 8'(8'hC0 + j));
        vprob[0] = 100;
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 20; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL bp_cyc got=%h want=%h", act_v, exp_v);
            end
            checks++;
            if (busy && stall) begin
                if (in_data !== pd) begin
                    errors++;
                    $display("FAIL bp_hold got=%h want=%h", in_data, pd);
                end
                checks++;
            end
            if (busy) nb++;
            stall = in_valid && !in_ready;
            pd = in_data;
        end
        if (nb != 10) begin
            errors++;
            $display("FAIL bp_busy got=%0d want=10", nb);
        end
        checks++;
        if (!rx_ok() || blen.size() != 1 || bowner[0] != 0) begin
            errors++;
            $display("FAIL bp_data got=%0d bursts want=1", blen.size());
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        for (int j = 0; j < 8; j++) push(1, 8'(8'h50 + j));
        vprob[1] = 100;
        while (rxq[1].size() < 3 && n < 20) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rmid_cyc got=%h want=%h", act_v, exp_v);
            end
            checks++;
            n++;
        end
        if (rxq[1].size() != 3) begin
            errors++;
            $display("FAIL rmid_pre got=%0d want=3", rxq[1].size());
        end
        checks++;
        rst = 1'b1;
        #1;
        if ({grant, busy, in_valid, in_data, req_ready} !== 18'h0) begin
            errors++;
            $display("FAIL rmid_async got=%h want=0",
                     {grant, busy, in_valid, in_data, req_ready});
        end
        checks++;
        for (int j = 0; j < 4; j++) push(0, 8'(8'h60 + j));
        vprob[0] = 100;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rmid_rst got=%h want=%h", act_v, exp_v);
            end
            checks++;
        end
        rst = 1'b0;
        bowner.delete();
        blen.delete();
        for (int i = 0; i < 30; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rmid_post got=%h want=%h", act_v, exp_v);
            end
            checks++;
        end
        if (bowner.size() < 1 || bowner[0] != 0) begin
            errors++;
            $display("FAIL rmid_first got=%0d want=0",
                     bowner.size() > 0 ? bowner[0] : -1);
        end
        checks++;
        if (rxq[1].size() < 4 || rxq[1][3] !== 8'h53) begin
            errors++;
            $display("FAIL rmid_resume got=%0d want=8", rxq[1].size());
        end
        checks++;
        if (!rx_ok()) begin
            errors++;
            $display("FAIL rmid_data got=bad want=no-loss-no-dup");
        end
        checks++;
    endtask

    task automatic test_rr4();
        int want[3] = '{3, 0, 2};
        do_reset();
        push(2, 8'hE0);
        vprob[2] = 100;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rr4_pre got=%h want=%h", act_v, exp_v);
            end
            checks++;
        end
        bowner.delete();
        blen.delete();
        for (int j = 0; j < 2; j++) begin
            push(0, 8'(8'h10 + j));
            push(2, 8'(8'h20 + j));
            push(3, 8'(8'h30 + j));
        end
        vprob[0] = 100;
        vprob[3] = 100;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rr4_cyc got=%h want=%h", act_v, exp_v);
            end
            checks++;
        end
        for (int j = 0; j < 3; j++) begin
            if (bowner.size() <= j || bowner[j] != want[j]) begin
                errors++;
                $display("FAIL rr4_order%0d got=%0d want=%0d", j,
                         bowner.size() > j ? bowner[j] : -1, want[j]);
            end
            checks++;
        end
        if (!rx_ok()) begin
            errors++;
            $display("FAIL rr4_data got=bad want=in-order");
        end
        checks++;
    endtask

    task automatic test_random();
        int left = 0;
        do_reset();
        for (int k = 0; k < N; k++) begin
            vprob[k] = 30 + int'($urandom_range(70));
            for (int j = 0; j < 20; j++) push(k, 8'($urandom));
        end
        rprob = 70;
        for (int i = 0; i < 700; i++) begin
            tick();
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rand_cyc got=%h want=%h", act_v, exp_v);
            end
            checks++;
        end
        for (int k = 0; k < N; k++) left += srcq[k].size();
        if (left != 0 || !rx_ok()) begin
            errors++;
            $display("FAIL rand_data got=%0d left want=0", left);
        end
        checks++;
    endtask

    initial begin
        m_owner = -1;
        m_cnt = 0;
        m_last = N - 1;
        test_reset();
        test_single();
        test_alternate();
        test_long();
        test_backpressure();
        test_reset_mid();
        test_rr4();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
